// File: rtl/sys_defs.sv
// rtl/sys_defs.sv - shared memory-bus types; XLEN defaults to 32 when not set by the build
`ifndef XLEN
`define XLEN 32
`endif

package sys_defs;

  localparam int MEM_TAG_W    = 4;
  localparam int NUM_MEM_TAGS = 16;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'd0,
    BUS_LOAD  = 2'd1,
    BUS_STORE = 2'd2
  } BUS_COMMAND;

  typedef enum logic {
    OWNER_DCACHE = 1'b0,
    OWNER_ICACHE = 1'b1
  } MEM_OWNER;

  typedef struct packed {
    BUS_COMMAND        command;
    logic [`XLEN-1:0]  addr;
    logic [63:0]       data;
  } MEM_REQ_PACKET;

endpackage

// File: rtl/mem_tag_table.sv
// rtl/mem_tag_table.sv - owner/valid record per in-flight memory tag, with orphan detection
// Retire is applied before allocate so a tag reused in the same cycle ends valid with its new owner.
module mem_tag_table
  import sys_defs::*;
(
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 alloc_en,
  input  logic [MEM_TAG_W-1:0] alloc_tag,
  input  MEM_OWNER             alloc_owner,
  input  logic [MEM_TAG_W-1:0] lookup_tag,
  output logic                 lookup_hit,
  output MEM_OWNER             lookup_owner,
  output logic                 orphan_tag
);

  logic [NUM_MEM_TAGS-1:0] valid;
  logic [NUM_MEM_TAGS-1:0] owner_ic;
  logic [NUM_MEM_TAGS-1:0] valid_next;
  logic [NUM_MEM_TAGS-1:0] owner_ic_next;
  logic                    lookup_miss;

  always_comb begin
    lookup_hit   = (lookup_tag != '0) && valid[lookup_tag];
    lookup_miss  = (lookup_tag != '0) && !valid[lookup_tag];
    lookup_owner = owner_ic[lookup_tag] ? OWNER_ICACHE : OWNER_DCACHE;
  end

  always_comb begin
    valid_next    = valid;
    owner_ic_next = owner_ic;
    if (lookup_hit) begin
      valid_next[lookup_tag] = 1'b0;
    end
    if (alloc_en && (alloc_tag != '0)) begin
      valid_next[alloc_tag]    = 1'b1;
      owner_ic_next[alloc_tag] = (alloc_owner == OWNER_ICACHE);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid      <= '0;
      owner_ic   <= '0;
      orphan_tag <= 1'b0;
    end else begin
      valid    <= valid_next;
      owner_ic <= owner_ic_next;
      if (lookup_miss) begin
        orphan_tag <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - icache/dcache arbiter for the single main-memory port with tag-owner routing
// Optional MEM_ARB_PERF_EN adds saturating grant counters on extra output ports.
module mem_arbiter
  import sys_defs::*;
#(
  parameter int unsigned STARVE_LIMIT           = 4,
  parameter int unsigned ICACHE_MAX_OUTSTANDING = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [1:0]         dcache_command,
  input  logic [`XLEN-1:0]   dcache_addr,
  input  logic [63:0]        dcache_data,
  input  logic [1:0]         icache_command,
  input  logic [`XLEN-1:0]   icache_addr,
  output logic [3:0]         dcache_response,
  output logic [3:0]         icache_response,
  output logic [3:0]         dcache_tag,
  output logic [3:0]         icache_tag,
  output logic [63:0]        mem_data_out,
  output logic [1:0]         proc2mem_command,
  output logic [`XLEN-1:0]   proc2mem_addr,
  output logic [63:0]        proc2mem_data,
  input  logic [3:0]         mem2proc_response,
  input  logic [63:0]        mem2proc_data,
  input  logic [3:0]         mem2proc_tag,
  output logic [3:0]         icache_outstanding,
  output logic               orphan_tag
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]        perf_dcache_grants,
  output logic [31:0]        perf_icache_grants,
  output logic [31:0]        perf_forced_grants
`endif
);

  localparam logic [3:0] STARVE_LIM4 = 4'(STARVE_LIMIT);

  logic [3:0]    starve_cnt;
  logic          starve_at_limit;
  logic          dc_elig, ic_elig;
  logic          grant_dc, grant_ic;
  logic          dc_accept, ic_accept;
  logic          ic_retire;
  logic          lookup_hit;
  MEM_OWNER      lookup_owner;
  MEM_REQ_PACKET dc_req, ic_req, win_req;

  // Reset gates eligibility so the memory port is idle while reset is held.
  always_comb begin
    starve_at_limit = (starve_cnt == STARVE_LIM4);
    dc_elig  = reset && (dcache_command != BUS_NONE);
    ic_elig  = reset && (icache_command == BUS_LOAD) &&
               (32'(icache_outstanding) < ICACHE_MAX_OUTSTANDING);
    grant_ic = ic_elig && (!dc_elig || starve_at_limit);
    grant_dc = dc_elig && !grant_ic;
  end

  always_comb begin
    dc_req = '{command: BUS_COMMAND'(dcache_command), addr: dcache_addr, data: dcache_data};
    ic_req = '{command: BUS_LOAD, addr: icache_addr, data: 64'd0};
    if (grant_ic) begin
      win_req = ic_req;
    end else if (grant_dc) begin
      win_req = dc_req;
    end else begin
      win_req = '0;
    end
  end

  always_comb begin
    proc2mem_command = win_req.command;
    proc2mem_addr    = win_req.addr;
    proc2mem_data    = win_req.data;
    dcache_response  = grant_dc ? mem2proc_response : 4'd0;
    icache_response  = grant_ic ? mem2proc_response : 4'd0;
    dc_accept        = grant_dc && (mem2proc_response != 4'd0);
    ic_accept        = grant_ic && (mem2proc_response != 4'd0);
    mem_data_out     = mem2proc_data;
    ic_retire        = lookup_hit && (lookup_owner == OWNER_ICACHE);
    icache_tag       = ic_retire ? mem2proc_tag : 4'd0;
    dcache_tag       = (lookup_hit && (lookup_owner == OWNER_DCACHE)) ? mem2proc_tag : 4'd0;
  end

  // Stores complete without a returning tag, so only loads claim a table entry.
  mem_tag_table u_tag_table (
    .clock        (clock),
    .reset        (reset),
    .alloc_en     (ic_accept || (dc_accept && (dcache_command == BUS_LOAD))),
    .alloc_tag    (mem2proc_response),
    .alloc_owner  (grant_ic ? OWNER_ICACHE : OWNER_DCACHE),
    .lookup_tag   (mem2proc_tag),
    .lookup_hit   (lookup_hit),
    .lookup_owner (lookup_owner),
    .orphan_tag   (orphan_tag)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      starve_cnt         <= 4'd0;
      icache_outstanding <= 4'd0;
    end else begin
      if (ic_accept) begin
        starve_cnt <= 4'd0;
      end else if (ic_elig && dc_accept && !starve_at_limit) begin
        starve_cnt <= starve_cnt + 4'd1;
      end
      case ({ic_accept, ic_retire})
        2'b10:   icache_outstanding <= icache_outstanding + 4'd1;
        2'b01:   icache_outstanding <= icache_outstanding - 4'd1;
        default: icache_outstanding <= icache_outstanding;
      endcase
    end
  end

`ifdef MEM_ARB_PERF_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      perf_dcache_grants <= 32'd0;
      perf_icache_grants <= 32'd0;
      perf_forced_grants <= 32'd0;
    end else begin
      if (dc_accept && (perf_dcache_grants != '1)) begin
        perf_dcache_grants <= perf_dcache_grants + 32'd1;
      end
      if (ic_accept && (perf_icache_grants != '1)) begin
        perf_icache_grants <= perf_icache_grants + 32'd1;
      end
      if (ic_accept && dc_elig && starve_at_limit && (perf_forced_grants != '1)) begin
        perf_forced_grants <= perf_forced_grants + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed and randomized self-checking bench for mem_arbiter
`ifndef XLEN
`define XLEN 32
`endif

module tb_mem_arbiter;

  localparam int SL   = 4;
  localparam int MAXO = 2;

  logic               clock = 1'b0;
  logic               reset = 1'b0;
  logic [1:0]         dcache_command = 2'd0;
  logic [`XLEN-1:0]   dcache_addr = '0;
  logic [63:0]        dcache_data = '0;
  logic [1:0]         icache_command = 2'd0;
  logic [`XLEN-1:0]   icache_addr = '0;
  logic [3:0]         dcache_response, icache_response, dcache_tag, icache_tag;
  logic [63:0]        mem_data_out;
  logic [1:0]         proc2mem_command;
  logic [`XLEN-1:0]   proc2mem_addr;
  logic [63:0]        proc2mem_data;
  logic [3:0]         mem2proc_response = '0;
  logic [63:0]        mem2proc_data = '0;
  logic [3:0]         mem2proc_tag = '0;
  logic [3:0]         icache_outstanding;
  logic               orphan_tag;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state: which tags are in flight and who owns them.
  bit m_valid [16];
  bit m_owner_ic [16];
  int m_starve;
  int m_out;
  bit m_orphan;

  logic [1:0]       e_cmd;
  logic [`XLEN-1:0] e_addr;
  logic [63:0]      e_data;
  logic [3:0]       e_dresp, e_iresp, e_dtag, e_itag;
  bit               e_ic_el;

  mem_arbiter #(.STARVE_LIMIT(SL), .ICACHE_MAX_OUTSTANDING(MAXO)) dut (
    .clock              (clock),
    .reset              (reset),
    .dcache_command     (dcache_command),
    .dcache_addr        (dcache_addr),
    .dcache_data        (dcache_data),
    .icache_command     (icache_command),
    .icache_addr        (icache_addr),
    .dcache_response    (dcache_response),
    .icache_response    (icache_response),
    .dcache_tag         (dcache_tag),
    .icache_tag         (icache_tag),
    .mem_data_out       (mem_data_out),
    .proc2mem_command   (proc2mem_command),
    .proc2mem_addr      (proc2mem_addr),
    .proc2mem_data      (proc2mem_data),
    .mem2proc_response  (mem2proc_response),
    .mem2proc_data      (mem2proc_data),
    .mem2proc_tag       (mem2proc_tag),
    .icache_outstanding (icache_outstanding),
    .orphan_tag         (orphan_tag)
  );

  initial forever #5 clock = ~clock;

  task automatic model_eval();
    bit dc_el, ic_win, dc_win;
    dc_el   = reset && (dcache_command != 2'd0);
    e_ic_el = reset && (icache_command == 2'd1) && (m_out < MAXO);
    ic_win  = e_ic_el && (!dc_el || m_starve == SL);
    dc_win  = dc_el && !ic_win;
    e_cmd   = ic_win ? 2'd1 : (dc_win ? dcache_command : 2'd0);
    e_addr  = ic_win ? icache_addr : (dc_win ? dcache_addr : '0);
    e_data  = dc_win ? dcache_data : 64'd0;
    e_dresp = dc_win ? mem2proc_response : 4'd0;
    e_iresp = ic_win ? mem2proc_response : 4'd0;
    e_dtag  = 4'd0;
    e_itag  = 4'd0;
    if (reset && mem2proc_tag != 4'd0 && m_valid[mem2proc_tag]) begin
      if (m_owner_ic[mem2proc_tag]) e_itag = mem2proc_tag;
      else e_dtag = mem2proc_tag;
    end
  endtask

  initial forever begin
    @(posedge clock or negedge reset);
    if (!reset) begin
      for (int t = 0; t < 16; t++) begin m_valid[t] = 0; m_owner_ic[t] = 0; end
      m_starve = 0;
      m_out    = 0;
      m_orphan = 0;
    end else if (clock) begin
      model_eval();
      if (mem2proc_tag != 4'd0) begin
        if (m_valid[mem2proc_tag]) begin
          m_valid[mem2proc_tag] = 0;
          if (m_owner_ic[mem2proc_tag]) m_out--;
        end else begin
          m_orphan = 1;
        end
      end
      if (e_dresp != 4'd0 && dcache_command == 2'd1) begin
        m_valid[e_dresp] = 1;
        m_owner_ic[e_dresp] = 0;
      end
      if (e_iresp != 4'd0) begin
        m_valid[e_iresp] = 1;
        m_owner_ic[e_iresp] = 1;
        m_out++;
      end
      if (e_iresp != 4'd0) m_starve = 0;
      else if (e_ic_el && e_dresp != 4'd0 && m_starve < SL) m_starve++;
    end
  end

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic [1:0] dc, input logic [31:0] da, input logic [63:0] dd,
                       input logic [1:0] ic, input logic [31:0] ia,
                       input logic [3:0] resp, input logic [3:0] mtag, input logic [63:0] mdata);
    dcache_command    = dc;
    dcache_addr       = da;
    dcache_data       = dd;
    icache_command    = ic;
    icache_addr       = ia;
    mem2proc_response = resp;
    mem2proc_tag      = mtag;
    mem2proc_data     = mdata;
  endtask

  task automatic do_reset();
    next_cycle();
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    next_cycle();
    next_cycle();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(2'd1, 32'h100, 64'h11, 2'd1, 32'h200, 4'd3, 4'd3, 64'h5);
    repeat (2) @(negedge clock);
    n_vec++;
    if (proc2mem_command !== 2'd0 || proc2mem_addr !== '0 || proc2mem_data !== 64'd0) begin
      n_err++;
      $display("FAIL reset_port cmd=%0d addr=%h data=%h expected 0 0 0", proc2mem_command, proc2mem_addr, proc2mem_data);
    end
    n_vec++;
    if ({dcache_response, icache_response, dcache_tag, icache_tag} !== 16'h0) begin
      n_err++;
      $display("FAIL reset_resp dresp=%0d iresp=%0d dtag=%0d itag=%0d expected all 0",
               dcache_response, icache_response, dcache_tag, icache_tag);
    end
    n_vec++;
    if (icache_outstanding !== 4'd0 || orphan_tag !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state outstanding=%0d orphan=%0d expected 0 0", icache_outstanding, orphan_tag);
    end
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;
  endtask

  task automatic test_priority();
    do_reset();
    drive(2'd1, 32'h100, 64'h0, 2'd1, 32'h200, 4'd3, 4'd0, 64'h0);
    @(negedge clock);
    n_vec++;
    if (dcache_response !== 4'd3 || icache_response !== 4'd0 || proc2mem_command !== 2'd1 || proc2mem_addr !== 32'h100) begin
      n_err++;
      $display("FAIL priority_grant dresp=%0d iresp=%0d cmd=%0d addr=%h expected 3 0 1 00000100",
               dcache_response, icache_response, proc2mem_command, proc2mem_addr);
    end
    next_cycle();
    drive(0, 0, 0, 0, 0, 4'd0, 4'd3, 64'hDEAD_BEEF);
    @(negedge clock);
    n_vec++;
    if (dcache_tag !== 4'd3 || icache_tag !== 4'd0 || mem_data_out !== 64'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL priority_return dtag=%0d itag=%0d data=%h expected 3 0 deadbeef", dcache_tag, icache_tag, mem_data_out);
    end
    next_cycle();
  endtask

  task automatic test_starvation();
    logic [3:0] exp_d, exp_i;
    do_reset();
    for (int i = 0; i < 6; i++) begin
      drive(2'd2, 32'h1000 + 32'(i), 64'(i), 2'd1, 32'h300, 4'(i + 1), 4'd0, 64'd0);
      exp_d = (i == 4) ? 4'd0 : 4'(i + 1);
      exp_i = (i == 4) ? 4'd5 : 4'd0;
      @(negedge clock);
      n_vec++;
      if (dcache_response !== exp_d || icache_response !== exp_i) begin
        n_err++;
        $display("FAIL starvation cyc=%0d dresp=%0d iresp=%0d expected %0d %0d", i, dcache_response, icache_response, exp_d, exp_i);
      end
      next_cycle();
    end
  endtask

  task automatic test_outstanding_cap();
    logic [3:0] resp_tbl [5] = '{4'd1, 4'd2, 4'd3, 4'd3, 4'd3};
    logic [3:0] mtag_tbl [5] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd0};
    logic [1:0] cmd_tbl  [5] = '{2'd1, 2'd1, 2'd0, 2'd0, 2'd1};
    logic [3:0] iresp_tbl[5] = '{4'd1, 4'd2, 4'd0, 4'd0, 4'd3};
    logic [3:0] itag_tbl [5] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd0};
    logic [3:0] out_tbl  [5] = '{4'd0, 4'd1, 4'd2, 4'd2, 4'd1};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(2'd0, 0, 0, 2'd1, 32'h400, resp_tbl[i], mtag_tbl[i], 64'd0);
      @(negedge clock);
      n_vec++;
      if (proc2mem_command !== cmd_tbl[i] || icache_response !== iresp_tbl[i] ||
          icache_tag !== itag_tbl[i] || icache_outstanding !== out_tbl[i]) begin
        n_err++;
        $display("FAIL outstanding_cap cyc=%0d cmd=%0d iresp=%0d itag=%0d out=%0d expected %0d %0d %0d %0d",
                 i, proc2mem_command, icache_response, icache_tag, icache_outstanding,
                 cmd_tbl[i], iresp_tbl[i], itag_tbl[i], out_tbl[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_reject();
    logic [3:0] resp_tbl [8] = '{4'd7, 4'd7, 4'd7, 4'd0, 4'd0, 4'd0, 4'd8, 4'd9};
    logic [3:0] dexp_tbl [8] = '{4'd7, 4'd7, 4'd7, 4'd0, 4'd0, 4'd0, 4'd8, 4'd0};
    logic [3:0] iexp_tbl [8] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd9};
    logic [1:0] cmd_tbl  [8] = '{2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      drive(2'd2, 32'h500, 64'h77, 2'd1, 32'h600, resp_tbl[i], 4'd0, 64'd0);
      @(negedge clock);
      n_vec++;
      if (dcache_response !== dexp_tbl[i] || icache_response !== iexp_tbl[i] || proc2mem_command !== cmd_tbl[i]) begin
        n_err++;
        $display("FAIL reject cyc=%0d dresp=%0d iresp=%0d cmd=%0d expected %0d %0d %0d",
                 i, dcache_response, icache_response, proc2mem_command, dexp_tbl[i], iexp_tbl[i], cmd_tbl[i]);
      end
      next_cycle();
    end
  endtask

  task automatic test_orphan_store();
    do_reset();
    drive(2'd2, 32'h700, 64'hABCD, 2'd0, 0, 4'd5, 4'd0, 64'd0);
    @(negedge clock);
    n_vec++;
    if (dcache_response !== 4'd5 || proc2mem_data !== 64'hABCD) begin
      n_err++;
      $display("FAIL store_accept dresp=%0d data=%h expected 5 abcd", dcache_response, proc2mem_data);
    end
    next_cycle();
    drive(0, 0, 0, 0, 0, 4'd0, 4'd5, 64'h1);
    @(negedge clock);
    n_vec++;
    if (dcache_tag !== 4'd0 || icache_tag !== 4'd0) begin
      n_err++;
      $display("FAIL orphan_route dtag=%0d itag=%0d expected 0 0", dcache_tag, icache_tag);
    end
    next_cycle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) @(negedge clock);
    n_vec++;
    if (orphan_tag !== 1'b1) begin
      n_err++;
      $display("FAIL orphan_sticky orphan=%0d expected 1", orphan_tag);
    end
    do_reset();
    @(negedge clock);
    n_vec++;
    if (orphan_tag !== 1'b0) begin
      n_err++;
      $display("FAIL orphan_clear orphan=%0d expected 0", orphan_tag);
    end
    next_cycle();
  endtask

  task automatic test_random();
    bit               dc_pend = 0, ic_pend = 0;
    logic [1:0]       dc_cmd = 0;
    logic [31:0]      dc_a = 0, ic_a = 0;
    logic [63:0]      dc_d = 0;
    logic [3:0]       resp, mtag;
    int               t0, t;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (c == 300) begin
        reset = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        next_cycle();
        reset = 1'b1;
        dc_pend = 0;
        ic_pend = 0;
      end
      if (!dc_pend && $urandom_range(0, 2) != 0) begin
        dc_pend = 1;
        dc_cmd  = 2'($urandom_range(1, 2));
        dc_a    = $urandom;
        dc_d    = {$urandom, $urandom};
      end
      if (!ic_pend && $urandom_range(0, 2) != 0) begin
        ic_pend = 1;
        ic_a    = $urandom;
      end
      mtag = 4'd0;
      if ($urandom_range(0, 29) == 0) begin
        mtag = 4'($urandom_range(1, 15));
      end else if ($urandom_range(0, 1) == 0) begin
        t0 = $urandom_range(1, 15);
        for (int k = 0; k < 15; k++) begin
          t = ((t0 - 1 + k) % 15) + 1;
          if (mtag == 4'd0 && m_valid[t]) mtag = 4'(t);
        end
      end
      resp = 4'd0;
      if ($urandom_range(0, 3) != 0) begin
        t = $urandom_range(1, 15);
        if (!m_valid[t] || 4'(t) == mtag) resp = 4'(t);
      end
      drive(dc_pend ? dc_cmd : 2'd0, dc_pend ? dc_a : 32'd0, dc_pend ? dc_d : 64'd0,
            ic_pend ? 2'd1 : 2'd0, ic_pend ? ic_a : 32'd0, resp, mtag, {$urandom, $urandom});
      @(negedge clock);
      model_eval();
      n_vec++;
      if ({proc2mem_command, proc2mem_addr, proc2mem_data, dcache_response, icache_response,
           dcache_tag, icache_tag, icache_outstanding, orphan_tag, mem_data_out} !==
          {e_cmd, e_addr, e_data, e_dresp, e_iresp, e_dtag, e_itag, 4'(m_out), m_orphan, mem2proc_data}) begin
        n_err++;
        $display("FAIL random cyc=%0d cmd=%0d/%0d addr=%h/%h dresp=%0d/%0d iresp=%0d/%0d dtag=%0d/%0d itag=%0d/%0d out=%0d/%0d orphan=%0d/%0d (got/expected)",
                 c, proc2mem_command, e_cmd, proc2mem_addr, e_addr, dcache_response, e_dresp,
                 icache_response, e_iresp, dcache_tag, e_dtag, icache_tag, e_itag,
                 icache_outstanding, m_out, orphan_tag, m_orphan);
      end
      if (e_dresp != 4'd0) dc_pend = 0;
      if (e_iresp != 4'd0) ic_pend = 0;
      next_cycle();
    end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_starvation();
    test_outstanding_cap();
    test_reject();
    test_orphan_store();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
